mips_decode_execute: RTL and testbench

MIPS_DECODE_EXECUTE -- requirements
Module: mips_decode_execute

---
 rtl/mips_decode_execute.sv | 113 +++++++++++
 tb/tb_mips_decode_execute.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS main/ALU decoders, sign extension and ALU; control and result are combinational.
// alu_result/zero/regwrite/memwrite/memtoreg are also registered with one cycle of latency; there is no backpressure.
module mips_decode_execute #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             memtoreg,
  output logic             memwrite,
  output logic             branch,
  output logic             alusrc,
  output logic             regdst,
  output logic             regwrite,
  output logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] sign_imm,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             pcsrc,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             zero_q,
  output logic             regwrite_q,
  output logic             memwrite_q,
  output logic             memtoreg_q
);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic [1:0]       aluop;
  logic [7:0]       controls;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             unused_rs_rt;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  // Register specifiers are consumed by the register file, not here.
  assign unused_rs_rt = ^instr[25:16];

  always_comb begin
    controls = 8'b000000_00;
    case (op)
      6'b000000: controls = 8'b110000_10;
      6'b100011: controls = 8'b101001_00;
      6'b101011: controls = 8'b001010_00;
      6'b000100: controls = 8'b000100_01;
      6'b001000: controls = 8'b101000_00;
      default:   controls = 8'b000000_00;
    endcase
  end

  assign {regwrite, regdst, alusrc, branch, memwrite, memtoreg, aluop} = controls;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  assign sign_imm = {{(WIDTH-16){imm[15]}}, imm};
  assign src_a    = rd1;
  assign src_b    = alusrc ? sign_imm : rd2;

  always_comb begin
    alu_result = '0;
    case (alucontrol)
      3'b000: alu_result = src_a & src_b;
      3'b001: alu_result = src_a | src_b;
      3'b010: alu_result = src_a + src_b;
      3'b110: alu_result = src_a - src_b;
      3'b100: alu_result = src_a & ~src_b;
      3'b101: alu_result = src_a | ~src_b;
      3'b111: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero  = (alu_result == '0);
  assign pcsrc = branch & zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      zero_q       <= zero;
      regwrite_q   <= regwrite;
      memwrite_q   <= memwrite;
      memtoreg_q   <= memtoreg;
    end
  end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Directed-vector bench for mips_decode_execute: combinational table plus register/reset sequences.
module tb_mips_decode_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rd1, rd2;
  logic        memtoreg, memwrite, branch, alusrc, regdst, regwrite;
  logic [2:0]  alucontrol;
  logic [31:0] sign_imm, alu_result, alu_result_q;
  logic        zero, pcsrc, zero_q, regwrite_q, memwrite_q, memtoreg_q;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_decode_execute #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .rd1(rd1), .rd2(rd2),
    .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch), .alusrc(alusrc),
    .regdst(regdst), .regwrite(regwrite), .alucontrol(alucontrol),
    .sign_imm(sign_imm), .alu_result(alu_result), .zero(zero), .pcsrc(pcsrc),
    .alu_result_q(alu_result_q), .zero_q(zero_q), .regwrite_q(regwrite_q),
    .memwrite_q(memwrite_q), .memtoreg_q(memtoreg_q)
  );

  // ctrl = {regwrite, regdst, alusrc, branch, memwrite, memtoreg}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [2:0]  aluc;
    logic [31:0] res;
    logic        zero;
    logic        pcsrc;
    logic [31:0] simm;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [31:0] i, logic [31:0] a, logic [31:0] b, logic [5:0] c,
                              logic [2:0] ac, logic [31:0] r, logic z, logic p, logic [31:0] s);
    vec_t v;
    v.instr = i; v.a = a; v.b = b; v.ctrl = c; v.aluc = ac;
    v.res = r; v.zero = z; v.pcsrc = p; v.simm = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] r, input logic z,
                       input logic rw, input logic mw, input logic mr);
    chk({tag, ".alu_result_q"}, alu_result_q, r);
    chk({tag, ".zero_q"}, {31'b0, zero_q}, {31'b0, z});
    chk({tag, ".regwrite_q"}, {31'b0, regwrite_q}, {31'b0, rw});
    chk({tag, ".memwrite_q"}, {31'b0, memwrite_q}, {31'b0, mw});
    chk({tag, ".memtoreg_q"}, {31'b0, memtoreg_q}, {31'b0, mr});
  endtask

  task automatic apply(input int k);
    instr = vecs[k].instr;
    rd1   = vecs[k].a;
    rd2   = vecs[k].b;
  endtask

  initial begin
    //             instr         rd1           rd2           ctrl       aluc    result        z     p     sign_imm
    vecs[0]  = mk(32'h00221820, 32'd5,        32'd7,        6'b110000, 3'b010, 32'd12,       1'b0, 1'b0, 32'h00001820); // add
    vecs[1]  = mk(32'h0022182A, 32'hFFFFFFFF, 32'd1,        6'b110000, 3'b111, 32'd1,        1'b0, 1'b0, 32'h0000182A); // slt -1<1
    vecs[2]  = mk(32'h0022182A, 32'h7FFFFFFF, 32'h80000000, 6'b110000, 3'b111, 32'd0,        1'b1, 1'b0, 32'h0000182A); // slt signed
    vecs[3]  = mk(32'h00221822, 32'd7,        32'd7,        6'b110000, 3'b110, 32'd0,        1'b1, 1'b0, 32'h00001822); // sub ->0
    vecs[4]  = mk(32'h00221822, 32'd0,        32'd1,        6'b110000, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00001822); // sub wrap
    vecs[5]  = mk(32'h00221820, 32'hFFFFFFFF, 32'd1,        6'b110000, 3'b010, 32'd0,        1'b1, 1'b0, 32'h00001820); // add wrap
    vecs[6]  = mk(32'h00221824, 32'hF0F000FF, 32'h0FF00F0F, 6'b110000, 3'b000, 32'h00F0000F, 1'b0, 1'b0, 32'h00001824); // and
    vecs[7]  = mk(32'h00221825, 32'hF0F000FF, 32'h0FF00F0F, 6'b110000, 3'b001, 32'hFFF00FFF, 1'b0, 1'b0, 32'h00001825); // or
    vecs[8]  = mk(32'h00221827, 32'hF0F000FF, 32'h0FF00F0F, 6'b110000, 3'b010, 32'h00E0100E, 1'b0, 1'b0, 32'h00001827); // unknown funct
    vecs[9]  = mk(32'h8C22FFFC, 32'd100,      32'd0,        6'b101001, 3'b010, 32'd96,       1'b0, 1'b0, 32'hFFFFFFFC); // lw
    vecs[10] = mk(32'hAC220008, 32'h10,       32'h99,       6'b001010, 3'b010, 32'h18,       1'b0, 1'b0, 32'h00000008); // sw
    vecs[11] = mk(32'h10220004, 32'd9,        32'd9,        6'b000100, 3'b110, 32'd0,        1'b1, 1'b1, 32'h00000004); // beq taken
    vecs[12] = mk(32'h10220004, 32'd9,        32'd8,        6'b000100, 3'b110, 32'd1,        1'b0, 1'b0, 32'h00000004); // beq not
    vecs[13] = mk(32'h20228000, 32'h00010000, 32'd5,        6'b101000, 3'b010, 32'h00008000, 1'b0, 1'b0, 32'hFFFF8000); // addi
    vecs[14] = mk(32'hFC221820, 32'd3,        32'd4,        6'b000000, 3'b010, 32'd7,        1'b0, 1'b0, 32'h00001820); // op 111111

    reset = 1'b0;
    instr = 32'h0;
    rd1   = 32'h0;
    rd2   = 32'h0;
    #2 reset = 1'b1;
    #1 chk_q("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held across an edge overrides capture.
    apply(0);
    @(posedge clk); #1;
    chk_q("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NV; k++) begin
      apply(k);
      #1;
      chk($sformatf("v%0d.ctrl", k), {26'b0, regwrite, regdst, alusrc, branch, memwrite, memtoreg},
          {26'b0, vecs[k].ctrl});
      chk($sformatf("v%0d.alucontrol", k), {29'b0, alucontrol}, {29'b0, vecs[k].aluc});
      chk($sformatf("v%0d.alu_result", k), alu_result, vecs[k].res);
      chk($sformatf("v%0d.zero", k), {31'b0, zero}, {31'b0, vecs[k].zero});
      chk($sformatf("v%0d.pcsrc", k), {31'b0, pcsrc}, {31'b0, vecs[k].pcsrc});
      chk($sformatf("v%0d.sign_imm", k), sign_imm, vecs[k].simm);
    end
    // Still in reset throughout the table.
    chk_q("reset_table", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release between edges; the first edge captures the add.
    @(negedge clk);
    apply(0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_q("first_edge", 32'd12, 1'b0, 1'b1, 1'b0, 1'b0);

    apply(10);
    @(posedge clk); #1;
    chk_q("sw_q", 32'h18, 1'b0, 1'b0, 1'b1, 1'b0);

    apply(9);
    @(posedge clk); #1;
    chk_q("lw_q", 32'd96, 1'b0, 1'b1, 1'b0, 1'b1);

    apply(11);
    #1;
    chk_q("q_holds", 32'd96, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_q("beq_q", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-cycle reset pulse clears at once; next edge after release reloads.
    apply(9);
    @(posedge clk); #1;
    chk_q("pre_pulse", 32'd96, 1'b0, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 chk_q("pulse", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #1 chk_q("post_pulse", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_q("reload", 32'd96, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
